header_stream_sequencer: RTL and testbench

- Parametrised successor to the fixed five-section header sequencer.
- Drives up to NUM_SRC header-section generators in index order, skipping masked-off sections. Example generators: frame header, matrix, picture header, slice size table, slice header.
- Registers the active generator's (val, size_of_bit, flush) words onto the single set_bit command bus.
- Tracks the running bitstream length and captures each section's byte offset, so size fields can be back-patched later.

---
 rtl/header_stream_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_header_stream_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/header_stream_sequencer.sv
// Header stream sequencer: walks the enabled section generators in index order,
// forwards their words onto the set_bit bus and records each section's byte offset.

module hss_lane #(
  parameter int LANE   = 0,
  parameter int IDX_W  = 3,
  parameter int VAL_W  = 64,
  parameter int SIZE_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  idx,
  input  logic              issue,
  input  logic              clear,
  input  logic [ADDR_W-1:0] byte_ofs,
  input  logic              valid,
  input  logic              flush,
  input  logic              fin,
  input  logic [VAL_W-1:0]  val,
  input  logic [SIZE_W-1:0] size_of_bit,
  output logic              kick,
  output logic              sel_valid,
  output logic              sel_flush,
  output logic              sel_done,
  output logic [VAL_W-1:0]  sel_val,
  output logic [SIZE_W-1:0] sel_size,
  output logic [ADDR_W-1:0] offset
);
  logic sel;

  assign sel       = (idx == IDX_W'(LANE));
  assign kick      = issue & sel;
  assign sel_valid = sel & valid;
  assign sel_flush = sel & flush;
  assign sel_done  = sel & fin;
  assign sel_val   = sel ? val : '0;
  assign sel_size  = sel ? size_of_bit : '0;

  // Offset is taken from the running bit count in the cycle the section is kicked.
  always_ff @(posedge clock) begin
    if (reset || clear) offset <= '0;
    else if (kick)      offset <= byte_ofs;
  end
endmodule

module header_stream_sequencer #(
  parameter int NUM_SRC = 5,
  parameter int VAL_W   = 64,
  parameter int SIZE_W  = 64,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_SRC-1:0]        src_mask,
  output logic [NUM_SRC-1:0]        src_start,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*VAL_W-1:0]  src_val,
  input  logic [NUM_SRC*SIZE_W-1:0] src_size_of_bit,
  input  logic [NUM_SRC-1:0]        src_flush,
  input  logic [NUM_SRC-1:0]        src_done,
  output logic                      sb_enable,
  output logic [VAL_W-1:0]          sb_val,
  output logic [SIZE_W-1:0]         sb_size_of_bit,
  output logic                      sb_flush,
  output logic [ADDR_W-1:0]         bit_count,
  output logic [NUM_SRC*ADDR_W-1:0] section_offset,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);
  // idx must be able to hold NUM_SRC so SELECT can see "past the last section".
  localparam int IDX_W = $clog2(NUM_SRC + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt, sel_idx;
  logic [WD_W-1:0]      wd, wd_nxt;
  logic [NUM_SRC-1:0]   mask_q;
  logic                 sel_hit, start_acc, issue, wd_expire, take;

  logic [NUM_SRC-1:0]             lane_valid, lane_flush, lane_done;
  logic [NUM_SRC-1:0][VAL_W-1:0]  lane_val;
  logic [NUM_SRC-1:0][SIZE_W-1:0] lane_size;

  logic                 act_valid, act_flush, act_done;
  logic [VAL_W-1:0]     act_val;
  logic [SIZE_W-1:0]    act_size, size_clamp;
  logic                 oversize;
  logic [ADDR_W-1:0]    byte_ofs, sum, sum_aligned;

  assign start_acc = (state == IDLE) && start;
  assign issue     = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign byte_ofs  = (bit_count >> 3) + ADDR_W'(bit_count[2:0] != 3'd0);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
    hss_lane #(
      .LANE(g), .IDX_W(IDX_W), .VAL_W(VAL_W), .SIZE_W(SIZE_W), .ADDR_W(ADDR_W)
    ) u_lane (
      .clock       (clock),
      .reset       (reset),
      .idx         (idx),
      .issue       (issue),
      .clear       (start_acc),
      .byte_ofs    (byte_ofs),
      .valid       (src_valid[g]),
      .flush       (src_flush[g]),
      .fin         (src_done[g]),
      .val         (src_val[g*VAL_W +: VAL_W]),
      .size_of_bit (src_size_of_bit[g*SIZE_W +: SIZE_W]),
      .kick        (src_start[g]),
      .sel_valid   (lane_valid[g]),
      .sel_flush   (lane_flush[g]),
      .sel_done    (lane_done[g]),
      .sel_val     (lane_val[g]),
      .sel_size    (lane_size[g]),
      .offset      (section_offset[g*ADDR_W +: ADDR_W])
    );
  end

  // Only the lane matching idx contributes, so an OR across lanes is the mux.
  always_comb begin
    act_valid = 1'b0;
    act_flush = 1'b0;
    act_done  = 1'b0;
    act_val   = '0;
    act_size  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      act_valid = act_valid | lane_valid[i];
      act_flush = act_flush | lane_flush[i];
      act_done  = act_done  | lane_done[i];
      act_val   = act_val   | lane_val[i];
      act_size  = act_size  | lane_size[i];
    end
  end

  // Lowest enabled section at or above idx; scanning downward leaves the lowest hit.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (mask_q[i] && (IDX_W'(i) >= idx)) begin
        sel_hit = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wd_nxt    = wd;
    wd_expire = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SELECT;
          idx_nxt   = '0;
        end
      end
      SELECT: begin
        if (sel_hit) begin
          state_nxt = ISSUE;
          idx_nxt   = sel_idx;
        end else begin
          state_nxt = DONE;
        end
      end
      ISSUE: begin
        wd_nxt    = '0;
        state_nxt = RUN;
      end
      RUN: begin
        if (act_done) begin
          idx_nxt   = idx + IDX_W'(1);
          wd_nxt    = '0;
          state_nxt = SELECT;
        end else if (act_valid) begin
          wd_nxt = '0;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          wd_expire = 1'b1;
          state_nxt = DONE;
        end else begin
          wd_nxt = wd + WD_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      wd     <= '0;
      mask_q <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      wd    <= wd_nxt;
      if (start_acc) mask_q <= src_mask;
    end
  end

  assign take        = (state == RUN) && act_valid;
  assign oversize    = act_size > SIZE_W'(VAL_W);
  assign size_clamp  = oversize ? SIZE_W'(VAL_W) : act_size;
  assign sum         = bit_count + ADDR_W'(size_clamp);
  // Flush aligns after the word's own bits are counted.
  assign sum_aligned = act_flush ? ((sum + ADDR_W'(7)) & ~ADDR_W'(7)) : sum;

  always_ff @(posedge clock) begin
    if (reset) begin
      sb_enable      <= 1'b0;
      sb_val         <= '0;
      sb_size_of_bit <= '0;
      sb_flush       <= 1'b0;
    end else begin
      sb_enable <= take;
      sb_flush  <= take & act_flush;
      if (take) begin
        sb_val         <= act_val;
        sb_size_of_bit <= size_clamp;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_count <= '0;
      error     <= 1'b0;
    end else if (start_acc) begin
      bit_count <= '0;
      error     <= 1'b0;
    end else begin
      if (take) bit_count <= sum_aligned;
      if ((take && oversize) || wd_expire) error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_header_stream_sequencer.sv
// Randomized bench for header_stream_sequencer: scripted generators plus a
// transaction-level model of word order, bit count, offsets, error and timing.
module tb_header_stream_sequencer;
  localparam int N  = 5;
  localparam int VW = 64;
  localparam int SW = 64;
  localparam int AW = 32;
  localparam int TO = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [N-1:0]    src_mask = '0, src_valid = '0, src_flush = '0, src_done = '0;
  logic [N-1:0]    src_start;
  logic [N*VW-1:0] src_val = '0;
  logic [N*SW-1:0] src_size_of_bit = '0;
  logic            sb_enable, sb_flush, busy, done, error;
  logic [VW-1:0]   sb_val;
  logic [SW-1:0]   sb_size_of_bit;
  logic [AW-1:0]   bit_count;
  logic [N*AW-1:0] section_offset;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { logic [63:0] v; logic [63:0] s; bit f; } wrd_t;

  int          nw[N];
  logic [63:0] wv[N][4];
  int          ws[N][4];
  bit          wf[N][4];
  bit          dsep[N];

  header_stream_sequencer #(
    .NUM_SRC(N), .VAL_W(VW), .SIZE_W(SW), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .src_mask(src_mask),
    .src_start(src_start), .src_valid(src_valid), .src_val(src_val),
    .src_size_of_bit(src_size_of_bit), .src_flush(src_flush), .src_done(src_done),
    .sb_enable(sb_enable), .sb_val(sb_val), .sb_size_of_bit(sb_size_of_bit),
    .sb_flush(sb_flush), .bit_count(bit_count), .section_offset(section_offset),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; src_valid = '0; src_flush = '0; src_done = '0;
    src_val = '0; src_size_of_bit = '0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) step();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".sb_en"}, sb_enable, 0);
    chk({nm, ".sb_val"}, sb_val, 0);
    chk({nm, ".sb_size"}, sb_size_of_bit, 0);
    chk({nm, ".sb_flush"}, sb_flush, 0);
    chk({nm, ".bc"}, bit_count, 0);
    chk({nm, ".ofs"}, 64'(section_offset != '0), 0);
    chk({nm, ".busy"}, busy, 0);
    chk({nm, ".done"}, done, 0);
    chk({nm, ".err"}, error, 0);
    chk({nm, ".sstart"}, src_start, 0);
  endtask

  // Inactive indices get random valid/done/flush that the DUT must ignore.
  task automatic drive_noise(input int act);
    for (int j = 0; j < N; j++) begin
      if (j == act) begin
        src_valid[j] = 1'b0; src_done[j] = 1'b0; src_flush[j] = 1'b0;
      end else begin
        src_valid[j] = 1'($urandom_range(0, 1));
        src_done[j]  = ($urandom_range(0, 3) == 0);
        src_flush[j] = 1'($urandom_range(0, 1));
      end
      src_val[j*VW +: VW]         = {$urandom, $urandom};
      src_size_of_bit[j*SW +: SW] = 64'($urandom_range(0, 100));
    end
  endtask

  task automatic gen_rand();
    for (int i = 0; i < N; i++) begin
      nw[i]   = $urandom_range(0, 3);
      dsep[i] = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        wv[i][k] = {$urandom, $urandom};
        ws[i][k] = ($urandom_range(0, 9) == 0) ? $urandom_range(65, 100) : $urandom_range(0, 64);
        wf[i][k] = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  task automatic run_seq(input logic [N-1:0] mask, input int silent, input int rst_src,
                         input string nm);
    int act = -1, pos = 0, gap = 0, nstart = 0, ndone = 0, dcyc = -1;
    int issue_c = 0, last_done_c = 0, exp_n, c = 0, got_i, exp_i;
    logic [31:0] mbc = 0;
    logic [31:0] moff[N];
    bit merr = 0;
    int sq[$];
    wrd_t wq[$];
    wrd_t w;
    for (int i = 0; i < N; i++) moff[i] = 0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        sq.push_back(i);
        if (i == silent) begin merr = 1; break; end
      end
    end
    exp_n = sq.size();

    drive_noise(-1);
    start = 1'b1; src_mask = mask;
    step(); c = 1; start = 1'b0;
    chk({nm, ".busy_after_start"}, busy, 1);
    chk({nm, ".err_cleared"}, error, 0);

    while (c < 600) begin
      if (src_start != '0) begin
        got_i = -1;
        for (int j = 0; j < N; j++) if (src_start[j]) got_i = j;
        exp_i = (sq.size() > 0) ? sq.pop_front() : -1;
        chk({nm, ".start_onehot"}, $countones(src_start), 1);
        chk({nm, ".start_idx"}, got_i, exp_i);
        if (nstart == 0) chk({nm, ".first_start_lat"}, c, 2);
        else             chk({nm, ".next_start_lat"}, c, last_done_c + 2);
        moff[got_i] = (mbc >> 3) + ((mbc[2:0] != 0) ? 1 : 0);
        act = got_i; pos = 0; gap = 1 + $urandom_range(0, 2); issue_c = c; nstart++;
        if (got_i != silent) begin
          for (int k = 0; k < nw[got_i]; k++) begin
            w.v = wv[got_i][k];
            w.s = (ws[got_i][k] > 64) ? 64 : ws[got_i][k];
            w.f = wf[got_i][k];
            if (ws[got_i][k] > 64) merr = 1;
            wq.push_back(w);
          end
        end
      end
      if (sb_enable) begin
        if (wq.size() == 0) chk({nm, ".extra_word"}, 1, 0);
        else begin
          w = wq.pop_front();
          chk({nm, ".sb_val"}, sb_val, w.v);
          chk({nm, ".sb_size"}, sb_size_of_bit, w.s);
          chk({nm, ".sb_flush"}, sb_flush, 64'(w.f));
          mbc = mbc + w.s[31:0];
          if (w.f) mbc = (mbc + 32'd7) & ~32'd7;
          chk({nm, ".bc_run"}, bit_count, mbc);
        end
      end
      if (dcyc >= 0 && c == dcyc + 1) begin
        chk({nm, ".busy_drop"}, busy, 0);
        chk({nm, ".done_pulse"}, done, 0);
        break;
      end
      if (done) begin ndone++; if (dcyc < 0) dcyc = c; act = -1; end

      if (rst_src >= 0 && act == rst_src && pos >= 1) begin
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all_zero({nm, ".after_reset"});
        for (int k = 0; k < 4; k++) begin
          step();
          chk({nm, ".no_kick_after_reset"}, src_start, 0);
        end
        return;
      end

      drive_noise(act);
      start = 1'b0;
      if (act >= 0 && act != silent) begin
        start = ($urandom_range(0, 4) == 0);
        if (gap > 0) gap--;
        else if (pos < nw[act]) begin
          src_valid[act] = 1'b1;
          src_val[act*VW +: VW] = wv[act][pos];
          src_size_of_bit[act*SW +: SW] = 64'(ws[act][pos]);
          src_flush[act] = wf[act][pos];
          pos++;
          gap = $urandom_range(0, 2);
          if (pos == nw[act] && !dsep[act]) begin
            src_done[act] = 1'b1; last_done_c = c; act = -1;
          end
        end else begin
          src_done[act] = 1'b1; last_done_c = c; act = -1;
        end
      end
      step(); c++;
    end

    chk({nm, ".bounded"}, 64'(c < 600), 1);
    chk({nm, ".done_count"}, ndone, 1);
    chk({nm, ".start_count"}, nstart, exp_n);
    chk({nm, ".words_left"}, wq.size(), 0);
    chk({nm, ".bc_final"}, bit_count, mbc);
    chk({nm, ".error"}, error, 64'(merr));
    for (int i = 0; i < N; i++)
      chk($sformatf("%s.ofs%0d", nm, i), section_offset[i*AW +: AW], moff[i]);
    if (mask == '0) chk({nm, ".empty_done_lat"}, dcyc, 2);
    else if (silent >= 0 && mask[silent]) chk({nm, ".timeout_lat"}, dcyc, issue_c + TO + 1);
    else chk({nm, ".done_lat"}, dcyc, last_done_c + 2);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    for (int i = 0; i < N; i++) begin
      nw[i] = 2; dsep[i] = 0;
      for (int k = 0; k < 4; k++) begin wv[i][k] = {$urandom, $urandom}; ws[i][k] = 32; wf[i][k] = 0; end
    end
    run_seq(5'b11111, -1, -1, "full");
    chk("full.bc320", bit_count, 320);
    for (int i = 0; i < N; i++) chk($sformatf("full.ofs_const%0d", i), section_offset[i*AW +: AW], i * 8);
    idle(2);

    gen_rand();
    run_seq(5'b10101, -1, -1, "skip");
    idle(2);

    nw[0] = 1; ws[0][0] = 12; wf[0][0] = 1; dsep[0] = 0;
    nw[1] = 1; ws[1][0] = 8;  wf[1][0] = 0; dsep[1] = 1;
    run_seq(5'b00011, -1, -1, "flush");
    chk("flush.bc24", bit_count, 24);
    chk("flush.ofs1", section_offset[AW +: AW], 2);
    idle(2);

    nw[0] = 1; ws[0][0] = 80; wf[0][0] = 0; dsep[0] = 0;
    run_seq(5'b00001, -1, -1, "oversize");
    idle(3);
    chk("oversize.sticky", error, 1);

    run_seq(5'b00000, -1, -1, "empty");
    idle(2);

    gen_rand();
    run_seq(5'b11111, 2, -1, "timeout");
    idle(2);

    gen_rand();
    nw[1] = 2;
    run_seq(5'b11111, -1, 1, "reset_mid");
    idle(1);
    gen_rand();
    run_seq(5'b11111, -1, -1, "restart");
    idle(2);

    for (int r = 0; r < 25; r++) begin
      gen_rand();
      run_seq(N'($urandom), -1, -1, $sformatf("rand%0d", r));
      idle($urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
